// File: rtl/aes_pkg.sv
// Shared AES constants and types used by the encryptor datapath and its
// output-side companions.
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES128_PIPE_LAT = 11;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage : aes_pkg

// File: rtl/aes_ct_fifo.sv
// Synchronous ciphertext FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter. The head
// entry is read combinationally from storage, with no bypass from the
// write port.
module aes_ct_fifo
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [BLOCK_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [BLOCK_W-1:0] pop_data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]        fill;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign fill    = wr_ptr_q - rd_ptr_q;
    assign count_o = CW'(fill);

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer state; storage contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule : aes_ct_fifo

// File: rtl/aes_enc_out_collector.sv
// Output collector for the stall-free pipelined AES-128 encryptor. A tag
// shift register mirrors the pipeline so the ciphertext is captured on the
// exact cycle it leaves the last round; issue credit is only granted while
// a FIFO slot can be reserved for every block in flight.
module aes_enc_out_collector
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int LATENCY = AES128_PIPE_LAT,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] enc_out,
    output logic [BLOCK_W-1:0] ct_data,
    output logic               ct_valid,
    input  logic               ct_ready,
    output logic               busy
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [LATENCY-1:0] tag_q, tag_d;
    logic [OW-1:0]      outstanding_q, outstanding_d;
    logic               issue;
    logic               pop;
    logic               capture;
    logic               fifo_empty;
    logic               fifo_full;
    logic [FW-1:0]      fifo_count;
    logic               unused_fifo_status;

    assign issue   = blk_valid & blk_ready;
    assign pop     = ct_valid & ct_ready;
    assign capture = tag_q[LATENCY-1];

    // Credit depends only on registered state and reset, never on blk_valid.
    assign blk_ready = (outstanding_q < DEPTH_C) & ~rst;
    assign busy      = (outstanding_q != '0);
    assign ct_valid  = ~fifo_empty;

    // Full and occupancy are implied by the outstanding counter, so the top
    // does not consume them.
    assign unused_fifo_status = ^{fifo_full, fifo_count};

    generate
        if (LATENCY == 1) begin : g_tag_single
            assign tag_d = issue;
        end else begin : g_tag_shift
            assign tag_d = {tag_q[LATENCY-2:0], issue};
        end
    endgenerate

    assign outstanding_d = outstanding_q + OW'(issue) - OW'(pop);

    // Pipeline tag tracking and outstanding-block accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q         <= '0;
            outstanding_q <= '0;
        end else begin
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
        end
    end

    aes_ct_fifo #(
        .BLOCK_W (BLOCK_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (capture),
        .push_data_i (enc_out),
        .pop_i       (pop),
        .pop_data_o  (ct_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule : aes_enc_out_collector

// File: tb/tb_aes_enc_out_collector.sv
// Directed bench for aes_enc_out_collector: a behavioural model of the
// pipeline timing and FIFO contents is updated every cycle while a linear
// sequence of scenarios drives the inputs.
module tb_aes_enc_out_collector;

    localparam int LAT   = 11;
    localparam int DEPTH = 16;

    logic         clk;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] enc_out;
    logic [127:0] ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic         busy;

    aes_enc_out_collector dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .enc_out   (enc_out),
        .ct_data   (ct_data),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit armed = 0;

    logic [127:0] blk_data;
    logic [127:0] drive_data [int];
    bit           live [int];
    logic [127:0] fifo_q [$];
    int           out_model = 0;
    int           n_issue = 0;
    int           n_pop = 0;
    int           first_valid, first_busy, last_busy;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_marks();
        first_valid = -1;
        first_busy  = -1;
        last_busy   = -1;
    endtask

    // One clock cycle: check outputs against the model, drive enc_out for
    // any block leaving the pipeline, then advance the model past the edge.
    task automatic tick();
        logic exp_ready, exp_valid, exp_busy, issue, pop;
        #1;
        exp_ready = (out_model < DEPTH) && !rst;
        exp_valid = (fifo_q.size() != 0);
        exp_busy  = (out_model != 0);
        if (armed) begin
            chk("blk_ready", {127'd0, blk_ready}, {127'd0, exp_ready});
            chk("ct_valid",  {127'd0, ct_valid},  {127'd0, exp_valid});
            chk("busy",      {127'd0, busy},      {127'd0, exp_busy});
            if (ct_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (busy === 1'b1) begin
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end
        end
        issue = blk_valid & exp_ready;
        pop   = exp_valid & ct_ready;
        if (armed && pop) chk("ct_data", ct_data, fifo_q[0]);
        if (issue) begin
            drive_data[cyc + LAT] = blk_data;
            live[cyc + LAT]       = 1'b1;
        end
        if (drive_data.exists(cyc)) enc_out = drive_data[cyc];
        else enc_out = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        if (rst) begin
            fifo_q.delete();
            live.delete();
            out_model = 0;
            armed = 1;
        end else begin
            if (pop) begin
                void'(fifo_q.pop_front());
                n_pop++;
            end
            if (issue) n_issue++;
            if (live.exists(cyc)) fifo_q.push_back(drive_data[cyc]);
            out_model = out_model + int'(issue) - int'(pop);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        blk_valid = 1'b0;
        ct_ready  = 1'b1;
        while ((out_model != 0 || fifo_q.size() != 0) && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed=%0d outstanding expected=0", out_model);
        end
    endtask

    int base_i, base_p, t0, guard;

    initial begin
        rst = 1'b1; blk_valid = 1'b0; ct_ready = 1'b0; enc_out = '0; blk_data = '0;
        clear_marks();

        // Reset for cycles 0..1, idle 2..4.
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();

        // Single block issued at cycle 5.
        clear_marks();
        chk("cycle_at_issue", 128'(cyc), 128'd5);
        blk_valid = 1'b1;
        blk_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_ready  = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (20) tick();
        chk("single_first_valid", 128'(first_valid), 128'd17);
        chk("single_first_busy",  128'(first_busy),  128'd6);
        chk("single_last_busy",   128'(last_busy),   128'd17);
        $display("single block: first_valid=%0d busy=%0d..%0d", first_valid, first_busy, last_busy);

        // Back-to-back: 20 issues with ct_ready=1.
        clear_marks();
        base_i = n_issue; base_p = n_pop; t0 = cyc;
        blk_valid = 1'b1;
        repeat (20) begin
            blk_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        drain();
        chk("b2b_issues",  128'(n_issue - base_i), 128'd20);
        chk("b2b_pops",    128'(n_pop - base_p),   128'd20);
        chk("b2b_latency", 128'(first_valid - t0), 128'd12);
        $display("back-to-back: issues=%0d pops=%0d", n_issue - base_i, n_pop - base_p);

        // Back-pressure: consumer stalled, upstream always offering.
        base_i = n_issue; base_p = n_pop;
        ct_ready = 1'b0; blk_valid = 1'b1;
        repeat (30) begin
            blk_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        chk("bp_issues",    128'(n_issue - base_i), 128'd16);
        chk("bp_ready_low", {127'd0, blk_ready},    128'd0);
        base_i = n_issue; base_p = n_pop;
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        tick();
        chk("bp_one_pop",   128'(n_pop - base_p),   128'd1);
        chk("bp_one_issue", 128'(n_issue - base_i), 128'd1);
        chk("bp_ready_still_low", {127'd0, blk_ready}, 128'd0);
        $display("back-pressure: one pop, one refill issue");
        drain();

        // Random traffic: 100 blocks with 50% consumer readiness.
        base_i = n_issue; base_p = n_pop; guard = 0;
        while ((n_issue - base_i) < 100 && guard < 3000) begin
            blk_valid = ($urandom_range(0, 9) < 7);
            ct_ready  = $urandom_range(0, 1);
            blk_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            guard++;
        end
        drain();
        chk("rand_issues", 128'(n_issue - base_i), 128'd100);
        chk("rand_pops",   128'(n_pop - base_p),   128'd100);
        $display("random: issues=%0d pops=%0d", n_issue - base_i, n_pop - base_p);

        // Mid-operation reset with 3 buffered and 5 in flight.
        ct_ready = 1'b0; blk_valid = 1'b1;
        repeat (3) begin
            blk_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        blk_valid = 1'b0;
        repeat (12) tick();
        blk_valid = 1'b1;
        repeat (5) begin
            blk_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        blk_valid = 1'b0;
        chk("pre_rst_valid", {127'd0, ct_valid}, 128'd1);
        chk("pre_rst_busy",  {127'd0, busy},     128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ct_ready = 1'b1;
        clear_marks();
        repeat (13) tick();
        chk("rst_mid_no_valid", 128'(first_valid), 128'(-1));
        chk("rst_mid_no_busy",  128'(first_busy),  128'(-1));
        $display("mid reset: stale outputs ignored");

        // Reset held for 4 cycles with upstream offering.
        rst = 1'b1; blk_valid = 1'b1;
        repeat (4) begin
            tick();
            chk("rst_hold_ready", {127'd0, blk_ready}, 128'd0);
        end
        rst = 1'b0; blk_valid = 1'b0;
        clear_marks();
        repeat (13) tick();
        chk("rst_hold_no_valid", 128'(first_valid), 128'(-1));
        $display("reset hold: no issue, no capture");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aes_enc_out_collector
